// File: rtl/rijndael_shiftrows_stream.sv
// rtl/rijndael_shiftrows_stream.sv - column-serial (Inv)ShiftRows for NB = 4/6/8 Rijndael blocks
// Optional double-buffered operation: define RIJNDAEL_SHIFTROWS_PINGPONG_EN.
module rijndael_shiftrows_stream #(
    parameter int NB = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        out_last,
    output logic        busy
);
    localparam int CW = $clog2(NB);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(NB - 1);
    localparam logic [CW:0] NBW = (CW + 1)'(NB);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
        $error("rijndael_shiftrows_stream: NB must be 4, 6 or 8");
    end

    // Rijndael-256 is the only block size whose last two rows skip an offset.
    function automatic logic [CW:0] shift_of(input int r);
        return (NB == 8 && r >= 2) ? (CW + 1)'(r + 1) : (CW + 1)'(r);
    endfunction

    cnt_t        wr_cnt;
    cnt_t        rd_cnt;
    logic        rd_inv;
    logic        accept;
    logic        emit;
    cnt_t        src [4];

    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;
    assign out_last = out_valid && (rd_cnt == LAST);
    assign busy     = (wr_cnt != '0) || out_valid;

    // Source column per row; explicit compare-and-subtract keeps non-power-of-two NB correct.
    always_comb begin
        logic [CW:0] sh;
        logic [CW:0] f_idx;
        logic [CW:0] i_idx;
        sh    = '0;
        f_idx = '0;
        i_idx = '0;
        src   = '{default: '0};
        for (int r = 0; r < 4; r++) begin
            sh    = shift_of(r);
            f_idx = {1'b0, rd_cnt} + sh;
            if (f_idx >= NBW) f_idx = f_idx - NBW;
            i_idx = {1'b0, rd_cnt} + NBW - sh;
            if (i_idx >= NBW) i_idx = i_idx - NBW;
            src[r] = rd_inv ? i_idx[CW-1:0] : f_idx[CW-1:0];
        end
    end

`ifdef RIJNDAEL_SHIFTROWS_PINGPONG_EN
    logic [31:0] mem [2][NB];
    logic [1:0]  full;
    logic [1:0]  mode;
    logic        wb;
    logic        rb;

    assign in_ready  = !full[wb];
    assign out_valid = full[rb];
    assign rd_inv    = mode[rb];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            full   <= '0;
            mode   <= '0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NB; i++)
                    mem[b][i] <= '0;
        end else begin
            if (accept) begin
                mem[wb][wr_cnt] <= in_col;
                if (wr_cnt == '0) mode[wb] <= in_inv;
                if (wr_cnt == LAST) begin
                    wr_cnt   <= '0;
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            // wb and rb never name the same bank here: one needs it FULL, the other not.
            if (emit) begin
                if (rd_cnt == LAST) begin
                    rd_cnt   <= '0;
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_col = '0;
        for (int r = 0; r < 4; r++)
            out_col[31-8*r -: 8] = mem[rb][src[r]][31-8*r -: 8];
    end
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t      state;
    state_t      state_nxt;
    logic [31:0] mem [NB];
    logic        mode;

    assign rd_inv = mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
            mode   <= 1'b0;
            for (int i = 0; i < NB; i++)
                mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mem[wr_cnt] <= in_col;
                if (wr_cnt == '0) mode <= in_inv;
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            end
            if (emit)
                rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && rd_cnt == LAST) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        out_col = '0;
        for (int r = 0; r < 4; r++)
            out_col[31-8*r -: 8] = mem[src[r]][31-8*r -: 8];
    end
`endif

endmodule

// File: tb/tb_rijndael_shiftrows_stream.sv
// tb/tb_rijndael_shiftrows_stream.sv - self-checking bench for rijndael_shiftrows_stream (NB = 4, 6, 8)
module tb_rijndael_shiftrows_stream;
    typedef logic [31:0] blk_t [8];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  in_inv;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  out_last;
    logic [2:0]  busy;
    logic [31:0] in_col  [3];
    logic [31:0] out_col [3];

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   stall_en = 1'b0;
    bit   pp_rec = 1'b0;
    logic [32:0] exp_q [3][$];
    bit          prev_hold [3];
    logic [31:0] prev_col  [3];
    int   emit_cyc [$];

    blk_t fips_in, fips_out, tmp, seq, rnd, mexp;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rijndael_shiftrows_stream #(.NB(g == 0 ? 4 : (g == 1 ? 6 : 8))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_col    (in_col[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_col   (out_col[g]),
            .out_last  (out_last[g]),
            .busy      (busy[g])
        );
    end

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic int nb_of(input int d);
        return d == 0 ? 4 : (d == 1 ? 6 : 8);
    endfunction

    // Reference: out[r][c] = in[r][(c +/- shift[r]) mod nb], straight from the row-rotation definition.
    function automatic void model(input int nb, input blk_t src, input bit inv, output blk_t dst);
        int s, k;
        dst = '{default: '0};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                s = (nb == 8 && r >= 2) ? r + 1 : r;
                k = inv ? (c - s + nb) % nb : (c + s) % nb;
                dst[c][31-8*r -: 8] = src[k][31-8*r -: 8];
            end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_block(input int d, input blk_t cols, input bit inv, input blk_t exp);
        int nb;
        bit got;
        int guard;
        nb = nb_of(d);
        for (int c = 0; c < nb; c++) exp_q[d].push_back({c == nb - 1, exp[c]});
        for (int c = 0; c < nb; c++) begin
            if (stall_en)
                while ($urandom_range(0, 2) == 0) begin
                    in_valid[d] = 1'b0;
                    in_inv[d]   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            in_valid[d] = 1'b1;
            in_col[d]   = cols[c];
            in_inv[d]   = (c == 0) ? inv : 1'($urandom_range(0, 1));
            got = 1'b0;
            guard = 0;
            while (!got && guard < 200) begin
                @(negedge clk);
                got = in_ready[d];
                @(posedge clk); #1;
                guard++;
            end
            if (!got) chk($sformatf("accept_timeout_dut%0d", d), 0, 1);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int guard;
        guard = 0;
        while (exp_q[d].size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (exp_q[d].size() != 0) chk($sformatf("drain_timeout_dut%0d", d), exp_q[d].size(), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++)
            out_ready[d] = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Compare process: every emit against the queued expectation, plus hold stability.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                prev_hold[d] = 1'b0;
            end else begin
                if (prev_hold[d]) begin
                    chk($sformatf("hold_valid_dut%0d", d), out_valid[d], 1'b1);
                    chk($sformatf("hold_col_dut%0d", d), out_col[d], prev_col[d]);
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (exp_q[d].size() == 0)
                        chk($sformatf("unexpected_emit_dut%0d", d), {out_last[d], out_col[d]}, 33'h0);
                    else
                        chk($sformatf("emit_dut%0d", d), {out_last[d], out_col[d]}, exp_q[d].pop_front());
                    if (pp_rec && d == 0) emit_cyc.push_back(cyc);
                end
                prev_hold[d] = out_valid[d] && !out_ready[d];
                prev_col[d]  = out_col[d];
            end
        end
    end

    initial begin
        int acc0;
        bit mode;
        in_valid = '0;
        in_inv   = '0;
        out_ready = 3'b111;
        for (int d = 0; d < 3; d++) in_col[d] = '0;
        fips_in  = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230, 0, 0, 0, 0};
        fips_out = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready%0d", d), in_ready[d], 1'b1);
            chk($sformatf("rst_out_valid%0d", d), out_valid[d], 1'b0);
            chk($sformatf("rst_out_last%0d", d), out_last[d], 1'b0);
            chk($sformatf("rst_out_col%0d", d), out_col[d], 32'h0);
            chk($sformatf("rst_busy%0d", d), busy[d], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model with hand-derived vectors.
        model(4, fips_in, 1'b0, tmp);
        for (int c = 0; c < 4; c++) chk($sformatf("model_fips_fwd%0d", c), tmp[c], fips_out[c]);
        model(4, fips_out, 1'b1, tmp);
        for (int c = 0; c < 4; c++) chk($sformatf("model_fips_inv%0d", c), tmp[c], fips_in[c]);
        for (int i = 0; i < 8; i++) seq[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        model(8, seq, 1'b0, mexp);
        chk("model_nb8_col0", mexp[0], 32'h00050e13);
        chk("model_nb8_col7", mexp[7], 32'h1c010a0f);

        // NB=4 known-answer, forward then inverse.
        send_block(0, fips_in, 1'b0, fips_out);
        chk("latency_out_valid", out_valid[0], 1'b1);
        wait_drain(0);
        send_block(0, fips_out, 1'b1, fips_in);
        wait_drain(0);

        // NB=8 and NB=6 round trips.
        send_block(2, seq, 1'b0, mexp);
        wait_drain(2);
        send_block(2, mexp, 1'b1, seq);
        wait_drain(2);
        for (int i = 0; i < 8; i++) rnd[i] = $urandom;
        model(6, rnd, 1'b0, tmp);
        send_block(1, rnd, 1'b0, tmp);
        wait_drain(1);
        send_block(1, tmp, 1'b1, rnd);
        wait_drain(1);

        // Random stalls on both handshakes, in_inv toggling mid-block.
        stall_en = 1'b1;
        send_block(0, fips_in, 1'b0, fips_out);
        wait_drain(0);
        for (int k = 0; k < 4; k++)
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 8; i++) rnd[i] = $urandom;
                mode = 1'($urandom_range(0, 1));
                model(nb_of(d), rnd, mode, tmp);
                send_block(d, rnd, mode, tmp);
            end
        for (int d = 0; d < 3; d++) wait_drain(d);
        stall_en = 1'b0;
        @(posedge clk); #1;

        // Reset in mid-fill discards the partial block.
        in_valid[0] = 1'b1;
        in_inv[0]   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_col[0] = fips_in[c];
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        chk("busy_mid_fill", busy[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid[0], 1'b0);
        chk("rst_mid_busy", busy[0], 1'b0);
        chk("rst_mid_in_ready", in_ready[0], 1'b1);
        chk("rst_mid_out_col", out_col[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", busy[0], 1'b0);
        send_block(0, fips_in, 1'b0, fips_out);
        wait_drain(0);

`ifdef RIJNDAEL_SHIFTROWS_PINGPONG_EN
        // Three back-to-back blocks with both handshakes always open.
        emit_cyc.delete();
        pp_rec = 1'b1;
        acc0 = 0;
        model(4, fips_in, 1'b0, tmp);
        for (int c = 0; c < 4; c++) exp_q[0].push_back({c == 3, tmp[c]});
        model(4, fips_out, 1'b1, tmp);
        for (int c = 0; c < 4; c++) exp_q[0].push_back({c == 3, tmp[c]});
        model(4, fips_in, 1'b0, tmp);
        for (int c = 0; c < 4; c++) exp_q[0].push_back({c == 3, tmp[c]});
        for (int i = 0; i < 12; i++) begin
            mode = (i / 4 == 1);
            in_valid[0] = 1'b1;
            in_col[0]   = (i / 4 == 1) ? fips_out[i % 4] : fips_in[i % 4];
            in_inv[0]   = (i % 4 == 0) ? mode : ~mode;
            @(negedge clk);
            chk($sformatf("pp_ready%0d", i), in_ready[0], 1'b1);
            if (i == 0) acc0 = cyc;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        wait_drain(0);
        pp_rec = 1'b0;
        chk("pp_emit_count", emit_cyc.size(), 12);
        for (int i = 0; i < emit_cyc.size(); i++)
            chk($sformatf("pp_emit_cycle%0d", i), emit_cyc[i], acc0 + 4 + i);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
